// File: rtl/fft_5_pkg.sv
// ---------------------------------------------------------------------------
// fft_5_pkg
// Shared constants and types for FFT stage 5 (complex multiplier + butterfly).
//   FFT5_DW    : width of stage data (X inputs, Y0/Y1 outputs), signed
//   FFT5_PW    : width of the multiplier product, signed, aligned to X scale
//   FFT5_SHIFT : per-stage arithmetic right shift (block scaling), 0..3
//   cplx_t     : complex product sample {re, im} at product width
//   acc_t      : complex butterfly accumulator {re, im} at product width + 1
// ---------------------------------------------------------------------------
package fft_5_pkg;

   localparam int FFT5_DW    = 12;
   localparam int FFT5_PW    = 24;
   localparam int FFT5_SHIFT = 1;

   typedef struct packed {
      logic signed [FFT5_PW-1:0] re;
      logic signed [FFT5_PW-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic signed [FFT5_PW:0] re;
      logic signed [FFT5_PW:0] im;
   } acc_t;

endpackage

// File: rtl/bfly_round_sat_5.sv
// ---------------------------------------------------------------------------
// bfly_round_sat_5
// Combinational round-half-up, arithmetic right shift and range reduction of
// one butterfly component from the exact accumulator width down to DW bits.
// Configuration macro: BUTTERFLY_5_SAT_EN
//   defined   : out-of-range results clamp to the nearest DW-bit extreme
//   undefined : out-of-range results wrap (low OW bits are kept)
// Ports:
//   s   in   IW  exact sum or difference from stage 1 (signed)
//   v   out  OW  rounded, shifted, range-reduced result (signed)
//   ovf out  1   result did not fit the OW-bit signed range
// ---------------------------------------------------------------------------
module bfly_round_sat_5 #(
   parameter int IW    = 25,
   parameter int OW    = 12,
   parameter int SHIFT = 1
) (
   input  logic signed [IW-1:0] s,
   output logic signed [OW-1:0] v,
   output logic                 ovf
);

   // One guard bit so the rounding constant can never overflow the sum.
   localparam int WW = IW + 1;
   localparam logic signed [WW-1:0] MAX_V = WW'((1 << (OW - 1)) - 1);
   localparam logic signed [WW-1:0] MIN_V = ~MAX_V;

   logic signed [WW-1:0] wide;
   logic signed [WW-1:0] shifted;

   assign wide = {s[IW-1], s};

   // Adding half an LSB before the floor-shift gives round-half-up.
   generate
      if (SHIFT > 0) begin : g_round
         logic signed [WW-1:0] rounded;
         assign rounded = wide + (WW'(1) << (SHIFT - 1));
         assign shifted = rounded >>> SHIFT;
      end else begin : g_noround
         assign shifted = wide;
      end
   endgenerate

   assign ovf = (shifted > MAX_V) || (shifted < MIN_V);

`ifdef BUTTERFLY_5_SAT_EN
   // Clamp to the representable extreme on overflow.
   always_comb begin
      v = shifted[OW-1:0];
      if (shifted > MAX_V) begin
         v = MAX_V[OW-1:0];
      end else if (shifted < MIN_V) begin
         v = MIN_V[OW-1:0];
      end
   end
`else
   assign v = shifted[OW-1:0];
`endif

endmodule

// File: rtl/butterfly_unit_5.sv
// ---------------------------------------------------------------------------
// butterfly_unit_5
// Radix-2 DIT butterfly for FFT stage 5. Combines upper operand X with the
// twiddled product P: Y0 = round(X+P)>>SHIFT, Y1 = round(X-P)>>SHIFT.
// Two-stage pipeline (exact add/sub, then round/shift/range-reduce) with
// valid/ready flow control; full throughput, 2-cycle latency.
// Configuration macro: BUTTERFLY_5_SAT_EN (saturate instead of wrap on overflow)
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake
//   x_re/x_im   [DW]    upper operand
//   p_re/p_im   [PW]    multiplier product
//   in_last             last butterfly of the frame
//   clr_ovf             synchronous clear of ovf_sticky
//   out_valid/out_ready output handshake
//   y0_re/y0_im [DW]    sum output
//   y1_re/y1_im [DW]    difference output
//   out_last            in_last aligned with its data
//   ovf_sticky          some result exceeded DW range since last clear
// ---------------------------------------------------------------------------
module butterfly_unit_5
   import fft_5_pkg::*;
#(
   parameter int DW    = FFT5_DW,
   parameter int PW    = FFT5_PW,
   parameter int SHIFT = FFT5_SHIFT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] x_re,
   input  logic signed [DW-1:0] x_im,
   input  logic signed [PW-1:0] p_re,
   input  logic signed [PW-1:0] p_im,
   input  logic                 in_last,
   input  logic                 clr_ovf,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] y0_re,
   output logic signed [DW-1:0] y0_im,
   output logic signed [DW-1:0] y1_re,
   output logic signed [DW-1:0] y1_im,
   output logic                 out_last,
   output logic                 ovf_sticky
);

   logic adv1, adv2;
   logic s1_valid, s1_last, s2_valid;
   logic signed [PW:0] x_re_ext, x_im_ext, p_re_ext, p_im_ext;
   logic signed [PW:0] s1_sum_re, s1_sum_im, s1_dif_re, s1_dif_im;
   logic signed [DW-1:0] r0_re, r0_im, r1_re, r1_im;
   logic ovf0_re, ovf0_im, ovf1_re, ovf1_im;
   logic any_ovf;

   // A stage may load when it is empty or its contents move on this cycle,
   // so a full pipeline keeps streaming while the output is being taken.
   assign adv2      = !s2_valid || out_ready;
   assign adv1      = !s1_valid || adv2;
   assign in_ready  = adv1;
   assign out_valid = s2_valid;

   // At PW+1 bits the add and subtract are exact for any X and P.
   assign x_re_ext = {{(PW + 1 - DW){x_re[DW-1]}}, x_re};
   assign x_im_ext = {{(PW + 1 - DW){x_im[DW-1]}}, x_im};
   assign p_re_ext = {p_re[PW-1], p_re};
   assign p_im_ext = {p_im[PW-1], p_im};

   // Stage 1: register the exact sum and difference.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_sum_re <= '0;
         s1_sum_im <= '0;
         s1_dif_re <= '0;
         s1_dif_im <= '0;
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_last   <= in_last;
            s1_sum_re <= x_re_ext + p_re_ext;
            s1_sum_im <= x_im_ext + p_im_ext;
            s1_dif_re <= x_re_ext - p_re_ext;
            s1_dif_im <= x_im_ext - p_im_ext;
         end
      end
   end

   bfly_round_sat_5 #(.IW(PW + 1), .OW(DW), .SHIFT(SHIFT)) u_y0_re (
      .s(s1_sum_re), .v(r0_re), .ovf(ovf0_re)
   );
   bfly_round_sat_5 #(.IW(PW + 1), .OW(DW), .SHIFT(SHIFT)) u_y0_im (
      .s(s1_sum_im), .v(r0_im), .ovf(ovf0_im)
   );
   bfly_round_sat_5 #(.IW(PW + 1), .OW(DW), .SHIFT(SHIFT)) u_y1_re (
      .s(s1_dif_re), .v(r1_re), .ovf(ovf1_re)
   );
   bfly_round_sat_5 #(.IW(PW + 1), .OW(DW), .SHIFT(SHIFT)) u_y1_im (
      .s(s1_dif_im), .v(r1_im), .ovf(ovf1_im)
   );

   assign any_ovf = ovf0_re || ovf0_im || ovf1_re || ovf1_im;

   // Stage 2: output registers. They only change on a move, so outputs stay
   // frozen while the downstream stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         out_last <= 1'b0;
         y0_re    <= '0;
         y0_im    <= '0;
         y1_re    <= '0;
         y1_im    <= '0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_last <= s1_last;
            y0_re    <= r0_re;
            y0_im    <= r0_im;
            y1_re    <= r1_re;
            y1_im    <= r1_im;
         end
      end
   end

   // Overflow is flagged when the offending result enters stage 2; a new
   // overflow takes priority over a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_sticky <= 1'b0;
      end else if (adv2 && s1_valid && any_ovf) begin
         ovf_sticky <= 1'b1;
      end else if (clr_ovf) begin
         ovf_sticky <= 1'b0;
      end
   end

endmodule

// File: tb/tb_butterfly_unit_5.sv
// ---------------------------------------------------------------------------
// tb_butterfly_unit_5
// Self-checking bench for butterfly_unit_5. Expected results come from an
// integer reference model (floor division, modulo wrap or clamp) and a FIFO
// scoreboard of accepted inputs.
// ---------------------------------------------------------------------------
module tb_butterfly_unit_5;
   import fft_5_pkg::*;

   localparam int DW    = FFT5_DW;
   localparam int PW    = FFT5_PW;
   localparam int SHIFT = FFT5_SHIFT;

   typedef struct packed {
      int   y0r;
      int   y0i;
      int   y1r;
      int   y1i;
      logic last;
   } res_t;

   logic                 clk;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic signed [DW-1:0] x_re, x_im;
   logic signed [PW-1:0] p_re, p_im;
   logic                 in_last;
   logic                 clr_ovf;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] y0_re, y0_im, y1_re, y1_im;
   logic                 out_last;
   logic                 ovf_sticky;

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];

   butterfly_unit_5 #(.DW(DW), .PW(PW), .SHIFT(SHIFT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .x_re(x_re), .x_im(x_im), .p_re(p_re), .p_im(p_im),
      .in_last(in_last), .clr_ovf(clr_ovf),
      .out_valid(out_valid), .out_ready(out_ready),
      .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
      .out_last(out_last), .ovf_sticky(ovf_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog");
   end

   // Mathematical floor of n/d for d > 0.
   function automatic int floor_div(input int n, input int d);
      if (n >= 0) return n / d;
      return -((-n + d - 1) / d);
   endfunction

   // Round half up to an integer multiple of 2^SHIFT, then scale down.
   function automatic int scale(input int s);
      int d;
      d = 2 ** SHIFT;
      return floor_div(s + d / 2, d);
   endfunction

   function automatic int reduce(input int v);
      int lim;
      int m;
      lim = 2 ** (DW - 1);
`ifdef BUTTERFLY_5_SAT_EN
      if (v > lim - 1) return lim - 1;
      if (v < -lim) return -lim;
      return v;
`else
      m = (v + lim) % (2 * lim);
      if (m < 0) m = m + 2 * lim;
      return m - lim;
`endif
   endfunction

   function automatic res_t model(input int xr, input int xi, input int pr, input int pi, input logic last);
      res_t r;
      r.y0r  = reduce(scale(xr + pr));
      r.y0i  = reduce(scale(xi + pi));
      r.y1r  = reduce(scale(xr - pr));
      r.y1i  = reduce(scale(xi - pi));
      r.last = last;
      return r;
   endfunction

   // Drives one cycle of stimulus starting at a falling edge, records an
   // accepted input into the scoreboard, and returns the output seen if a
   // transfer happens at the coming rising edge. Ends at the next falling edge.
   task automatic applyStimulus(input logic iv, input int xr, input int xi, input int pr, input int pi,
                                input logic il, input logic ordy,
                                output logic fired, output res_t got, output logic acc);
      in_valid  = iv;
      x_re      = xr[DW-1:0];
      x_im      = xi[DW-1:0];
      p_re      = pr[PW-1:0];
      p_im      = pi[PW-1:0];
      in_last   = il;
      out_ready = ordy;
      #1;
      acc = iv && in_ready;
      if (acc) exp_q.push_back(model(xr, xi, pr, pi, il));
      fired    = out_valid && out_ready;
      got.y0r  = y0_re;
      got.y0i  = y0_im;
      got.y1r  = y1_re;
      got.y1i  = y1_im;
      got.last = out_last;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_sample(output int xr, output int xi, output int pr, output int pi, output logic last);
      int r;
      xr = int'($urandom_range(4095)) - 2048;
      xi = int'($urandom_range(4095)) - 2048;
      if ($urandom_range(3) != 0) begin
         pr = int'($urandom_range(5000)) - 2500;
         pi = int'($urandom_range(5000)) - 2500;
      end else begin
         r  = int'($urandom);
         pr = r >>> 8;
         r  = int'($urandom);
         pi = r >>> 8;
      end
      last = 1'($urandom_range(1));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || ovf_sticky !== 1'b0 || y0_re !== '0 || y1_im !== '0 || out_last !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_state: out_valid=%b ovf=%b y0_re=%0d y1_im=%0d last=%b, required all 0",
                  out_valid, ovf_sticky, y0_re, y1_im, out_last);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_in_ready: in_ready=%b required 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic f, a;
      res_t g, want;
      exp_q.delete();
      applyStimulus(1, 100, 50, 20, -10, 0, 1, f, g, a);
      checks++;
      if (a !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_accept: accepted=%b required 1", a);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1, f, g, a);
      checks++;
      if (f !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_latency_early: out_valid=%b required 0 one cycle after accept", f);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1, f, g, a);
      want = '{y0r: 60, y0i: 20, y1r: 40, y1i: 30, last: 1'b0};
      checks++;
      if (f !== 1'b1 || g !== want) begin
         errors++;
         $display("[TB] FAIL basic_result: valid=%b Y0=(%0d,%0d) Y1=(%0d,%0d), required valid=1 Y0=(60,20) Y1=(40,30)",
                  f, g.y0r, g.y0i, g.y1r, g.y1i);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1, f, g, a);
      checks++;
      if (f !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_single_pulse: out_valid=%b required 0", f);
      end
      // Round half up: 121/2 -> 61, -121/2 -> -60, -1/2 -> 0, 1/2 -> 1.
      applyStimulus(1, 60, -60, 61, -61, 1, 1, f, g, a);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, f, g, a);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, f, g, a);
      want = '{y0r: 61, y0i: -60, y1r: 0, y1i: 1, last: 1'b1};
      checks++;
      if (f !== 1'b1 || g !== want) begin
         errors++;
         $display("[TB] FAIL rounding: valid=%b Y0=(%0d,%0d) Y1=(%0d,%0d) last=%b, required Y0=(61,-60) Y1=(0,1) last=1",
                  f, g.y0r, g.y0i, g.y1r, g.y1i, g.last);
      end
      exp_q.delete();
   endtask

   task automatic test_overflow();
      logic f, a;
      res_t g, want;
      exp_q.delete();
      clr_ovf = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 1, f, g, a);
      clr_ovf = 1'b0;
      want = model(2047, 0, 4000, 0, 0);
      applyStimulus(1, 2047, 0, 4000, 0, 0, 1, f, g, a);
      checks++;
      if (ovf_sticky !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovf_early: ovf_sticky=%b required 0 before stage 2 load", ovf_sticky);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1, f, g, a);
      checks++;
      if (ovf_sticky !== 1'b1 || out_valid !== 1'b1 || int'(y0_re) != want.y0r || int'(y1_re) != want.y1r) begin
         errors++;
         $display("[TB] FAIL ovf_result: ovf=%b valid=%b y0_re=%0d y1_re=%0d, required ovf=1 valid=1 y0_re=%0d y1_re=%0d",
                  ovf_sticky, out_valid, y0_re, y1_re, want.y0r, want.y1r);
      end
      repeat (4) applyStimulus(1, 5, 5, 5, 5, 0, 1, f, g, a);
      checks++;
      if (ovf_sticky !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_sticky_hold: ovf_sticky=%b required 1", ovf_sticky);
      end
      clr_ovf = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 1, f, g, a);
      clr_ovf = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovf_clear: ovf_sticky=%b required 0", ovf_sticky);
      end
      applyStimulus(1, -2048, 0, 3000, 0, 0, 1, f, g, a);
      clr_ovf = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 1, f, g, a);
      clr_ovf = 1'b0;
      checks++;
      if (ovf_sticky !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_set_wins: ovf_sticky=%b required 1", ovf_sticky);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1, f, g, a);
      clr_ovf = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 1, f, g, a);
      clr_ovf = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_backpressure();
      logic f, a;
      res_t g, e;
      int xr[4], xi[4], pr[4], pi[4];
      logic lst[4];
      int sent, outs;
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         rand_sample(xr[k], xi[k], pr[k], pi[k], lst[k]);
         lst[k] = (k == 3);
      end
      sent = 0;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(sent < 4, xr[sent % 4], xi[sent % 4], pr[sent % 4], pi[sent % 4], lst[sent % 4], 0, f, g, a);
         if (a) sent++;
      end
      #1;
      e = model(xr[0], xi[0], pr[0], pi[0], lst[0]);
      checks++;
      if (sent != 2 || in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_stall: accepts=%0d in_ready=%b, required accepts=2 in_ready=0", sent, in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || int'(y0_re) != e.y0r) begin
         errors++;
         $display("[TB] FAIL bp_hold: valid=%b y0_re=%0d, required valid=1 y0_re=%0d", out_valid, y0_re, e.y0r);
      end
      outs = 0;
      for (int c = 0; c < 30 && outs < 4; c++) begin
         applyStimulus(sent < 4, xr[sent % 4], xi[sent % 4], pr[sent % 4], pi[sent % 4], lst[sent % 4], 1, f, g, a);
         if (a) sent++;
         if (f) begin
            outs++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL bp_extra_output: got an output with nothing outstanding");
            end else begin
               e = exp_q.pop_front();
               if (g !== e) begin
                  errors++;
                  $display("[TB] FAIL bp_order[%0d]: got Y0=(%0d,%0d) Y1=(%0d,%0d) last=%b, required Y0=(%0d,%0d) Y1=(%0d,%0d) last=%b",
                           outs, g.y0r, g.y0i, g.y1r, g.y1i, g.last, e.y0r, e.y0i, e.y1r, e.y1i, e.last);
               end
            end
         end
      end
      checks++;
      if (outs != 4 || exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL bp_count: outputs=%0d left=%0d, required outputs=4 left=0", outs, exp_q.size());
      end
   endtask

   // mode 0: continuous in_valid with out_ready toggling 1010...
   // mode 1: random in_valid and out_ready
   task automatic test_stream(input int mode, input int n);
      logic f, a, iv, ordy;
      res_t g, e;
      int xr, xi, pr, pi;
      logic lst;
      int sent, recv, cyc;
      exp_q.delete();
      sent = 0;
      recv = 0;
      cyc  = 0;
      rand_sample(xr, xi, pr, pi, lst);
      while (recv < n && cyc < 20 * n + 50) begin
         ordy = (mode == 0) ? ((cyc % 2) == 0) : ($urandom_range(3) != 0);
         iv   = (sent < n) && ((mode == 0) ? 1'b1 : 1'($urandom_range(1)));
         applyStimulus(iv, xr, xi, pr, pi, lst, ordy, f, g, a);
         if (a) begin
            sent++;
            rand_sample(xr, xi, pr, pi, lst);
         end
         if (f) begin
            recv++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL stream%0d_extra: output %0d with nothing outstanding", mode, recv);
            end else begin
               e = exp_q.pop_front();
               if (g !== e) begin
                  errors++;
                  $display("[TB] FAIL stream%0d_data[%0d]: got Y0=(%0d,%0d) Y1=(%0d,%0d) last=%b, required Y0=(%0d,%0d) Y1=(%0d,%0d) last=%b",
                           mode, recv, g.y0r, g.y0i, g.y1r, g.y1i, g.last, e.y0r, e.y0i, e.y1r, e.y1i, e.last);
               end
            end
         end
         cyc++;
      end
      checks++;
      if (recv != n || sent != n || exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL stream%0d_count: sent=%0d received=%0d left=%0d, required %0d each, 0 left",
                  mode, sent, recv, exp_q.size(), n);
      end
   endtask

   task automatic test_reset_midflight();
      logic f, a;
      res_t g, want;
      exp_q.delete();
      applyStimulus(1, 2047, 2047, 4000, 0, 0, 0, f, g, a);
      applyStimulus(1, 10, 20, 30, 40, 0, 0, f, g, a);
      in_valid = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b1 || ovf_sticky !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_fill: valid=%b ovf=%b in_ready=%b, required 1 1 0", out_valid, ovf_sticky, in_ready);
      end
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || ovf_sticky !== 1'b0 || y0_re !== '0) begin
         errors++;
         $display("[TB] FAIL rst_async: valid=%b ovf=%b y0_re=%0d, required 0 0 0", out_valid, ovf_sticky, y0_re);
      end
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      applyStimulus(1, 100, 50, 20, -10, 0, 1, f, g, a);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, f, g, a);
      checks++;
      if (f !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rst_stale_output: out_valid=%b required 0 after reset", f);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 1, f, g, a);
      want = '{y0r: 60, y0i: 20, y1r: 40, y1i: 30, last: 1'b0};
      checks++;
      if (a !== 1'b0 || f !== 1'b1 || g !== want) begin
         errors++;
         $display("[TB] FAIL rst_first_result: valid=%b Y0=(%0d,%0d) Y1=(%0d,%0d), required valid=1 Y0=(60,20) Y1=(40,30)",
                  f, g.y0r, g.y0i, g.y1r, g.y1i);
      end
      exp_q.delete();
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      x_re      = '0;
      x_im      = '0;
      p_re      = '0;
      p_im      = '0;
      in_last   = 1'b0;
      clr_ovf   = 1'b0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_stream(0, 16);
      test_stream(1, 200);
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
